// File: rtl/tpu_pkg.sv
// Shared TPU definitions: SYNC responder state encoding, busy-line bit
// positions and a small saturating counter helper.
package tpu_pkg;

    typedef enum logic [2:0] {
        IDLE,
        GRACE,
        WAIT,
        DONE,
        TMO
    } sync_state_t;

    localparam int SYNC_SYS_BIT = 0;
    localparam int SYNC_VPU_BIT = 1;
    localparam int SYNC_DMA_BIT = 2;
    localparam int SYNC_WT_BIT  = 3;

    // Cycle counter that sticks at all-ones instead of wrapping.
    function automatic logic [15:0] sat_inc16(input logic [15:0] value);
        return (value == 16'hFFFF) ? value : value + 16'd1;
    endfunction

endpackage

// File: rtl/tpu_sync_unit_if.sv
// SYNC handshake between tpu_controller (master) and tpu_sync_unit (slave).
interface tpu_sync_unit_if;

    logic        sync_wait;
    logic [3:0]  sync_mask;
    logic [15:0] sync_timeout;
    logic        sync_abort;
    logic        sync_stall;
    logic        sync_done;
    logic        sync_tmo;

    modport master (
        output sync_wait, sync_mask, sync_timeout, sync_abort,
        input  sync_stall, sync_done, sync_tmo
    );

    modport slave (
        input  sync_wait, sync_mask, sync_timeout, sync_abort,
        output sync_stall, sync_done, sync_tmo
    );

endinterface

// File: rtl/tpu_sync_unit.sv
// SYNC responder: accepts a request edge, ignores busy lines for a grace
// window, then waits for the masked units to go idle or for the timeout,
// and retires the SYNC with a one-cycle done or timeout pulse.
module tpu_sync_unit
    import tpu_pkg::*;
#(
    parameter int GRACE_CYCLES = 2,
    parameter int TMO_CNT_W    = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    tpu_sync_unit_if.slave       sync_bus,
    input  logic                 sys_busy,
    input  logic                 vpu_busy,
    input  logic                 dma_busy,
    input  logic                 wt_busy,
    output logic [3:0]           tmo_busy_snap,
    output logic [TMO_CNT_W-1:0] tmo_count,
    output logic [15:0]          last_wait_cycles
);

    localparam logic [3:0] GRACE_INIT = 4'(GRACE_CYCLES);

    sync_state_t          state;
    logic                 wait_q;
    logic [15:0]          wait_cnt;
    logic [3:0]           grace_cnt;
    logic [3:0]           mask_r;
    logic [15:0]          tmo_r;

    logic [3:0]           busy_vec;
    logic [3:0]           busy_masked;
    logic                 request;
    logic                 all_idle;
    logic                 tmo_hit;
    logic [TMO_CNT_W-1:0] tmo_count_next;

    assign busy_vec[SYNC_SYS_BIT] = sys_busy;
    assign busy_vec[SYNC_VPU_BIT] = vpu_busy;
    assign busy_vec[SYNC_DMA_BIT] = dma_busy;
    assign busy_vec[SYNC_WT_BIT]  = wt_busy;

    assign busy_masked    = busy_vec & mask_r;
    assign all_idle       = (busy_masked == 4'd0);
    assign request        = sync_bus.sync_wait & ~wait_q;
    assign tmo_hit        = (tmo_r != 16'd0) && (wait_cnt >= tmo_r);
    assign tmo_count_next = (tmo_count == '1) ? tmo_count : tmo_count + TMO_CNT_W'(1);

    // Remember the previous request level so only a rising edge starts a SYNC.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_q <= 1'b0;
        end else begin
            wait_q <= sync_bus.sync_wait;
        end
    end

    // SYNC sequencing; abort beats completion, completion beats timeout.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= IDLE;
            wait_cnt         <= 16'd0;
            grace_cnt        <= 4'd0;
            mask_r           <= 4'd0;
            tmo_r            <= 16'd0;
            tmo_busy_snap    <= 4'd0;
            tmo_count        <= '0;
            last_wait_cycles <= 16'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (request) begin
                        state     <= GRACE;
                        mask_r    <= sync_bus.sync_mask;
                        tmo_r     <= sync_bus.sync_timeout;
                        wait_cnt  <= 16'd1;
                        grace_cnt <= GRACE_INIT;
                    end
                end
                GRACE: begin
                    if (sync_bus.sync_abort) begin
                        state <= IDLE;
                    end else if (tmo_hit) begin
                        state            <= TMO;
                        last_wait_cycles <= wait_cnt;
                        tmo_busy_snap    <= busy_masked;
                        tmo_count        <= tmo_count_next;
                    end else begin
                        wait_cnt  <= sat_inc16(wait_cnt);
                        grace_cnt <= grace_cnt - 4'd1;
                        if (grace_cnt <= 4'd1) begin
                            state <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (sync_bus.sync_abort) begin
                        state <= IDLE;
                    end else if (all_idle) begin
                        state            <= DONE;
                        last_wait_cycles <= wait_cnt;
                    end else if (tmo_hit) begin
                        state            <= TMO;
                        last_wait_cycles <= wait_cnt;
                        tmo_busy_snap    <= busy_masked;
                        tmo_count        <= tmo_count_next;
                    end else begin
                        wait_cnt <= sat_inc16(wait_cnt);
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                TMO: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign sync_bus.sync_stall = (state == GRACE) || (state == WAIT);
    assign sync_bus.sync_done  = (state == DONE);
    assign sync_bus.sync_tmo   = (state == TMO);

endmodule
